// File: rtl/mc_control.sv
// mc_control: multi-cycle Moore control unit for the lab05 MIPS-subset CPU.
// It steps FETCH/DECODE/execute/memory/writeback and drives the datapath
// selects, the strobes and the ALU operation code. It also counts retired
// instructions. The current state is visible on the state port for debug.
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_en,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9, S_I_EXEC = 4'd10, S_I_WB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LW = 6'h23,
                         OP_SW = 6'h2B;

  localparam logic [2:0] ALU_NOP = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2,
                         ALU_AND = 3'd3, ALU_OR = 3'd4, ALU_XOR = 3'd5,
                         ALU_NOR = 3'd6;

  state_t           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [5:0]       funct_q, funct_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_dec;

  // R-type funct to ALU operation; NOP marks an unsupported funct.
  function automatic logic [2:0] r_alu_op(input logic [5:0] f);
    case (f)
      6'h20:   r_alu_op = ALU_ADD;
      6'h22:   r_alu_op = ALU_SUB;
      6'h24:   r_alu_op = ALU_AND;
      6'h25:   r_alu_op = ALU_OR;
      6'h26:   r_alu_op = ALU_XOR;
      6'h27:   r_alu_op = ALU_NOR;
      default: r_alu_op = ALU_NOP;
    endcase
  endfunction

  // Immediate-class opcode to ALU operation (used in I_EXEC and held in I_WB).
  function automatic logic [2:0] i_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: i_alu_op = ALU_AND;
      OP_ORI:  i_alu_op = ALU_OR;
      OP_XORI: i_alu_op = ALU_XOR;
      default: i_alu_op = ALU_ADD;
    endcase
  endfunction

  // State, latched IR fields and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      opcode_q <= 6'd0;
      funct_q  <= 6'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state; DECODE decides from the live IR fields and latches them.
  always_comb begin
    state_d     = S_FETCH;
    opcode_d    = opcode_q;
    funct_d     = funct_q;
    illegal_dec = 1'b0;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = opcode;
        funct_d  = funct;
        case (opcode)
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
          OP_RTYPE: begin
            if (r_alu_op(funct) != ALU_NOP) state_d = S_R_EXEC;
            else                            illegal_dec = 1'b1;
          end
          default:                          illegal_dec = 1'b1;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
    // An instruction retires on every return to FETCH, except a rejected one.
    cnt_d = ((state_d == S_FETCH) && !illegal_dec) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Moore outputs per state; strobes are held low while reset is asserted.
  always_comb begin
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_zero   = 1'b0;
    alu_op     = ALU_NOP;
    pc_source  = 2'b00;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_en     = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        illegal   = illegal_dec;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op(funct_q);
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_EXEC, S_I_WB: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_zero  = (opcode_q != OP_ADDI);
        alu_op    = i_alu_op(opcode_q);
        reg_write = (state_q == S_I_WB);
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = 2'b01;
        pc_en     = zero ^ (opcode_q == OP_BNE);
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_en     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control, built with a 4-bit counter so wrap is reachable.
module tb_mc_control;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, ext_zero, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [3:0] instr_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cnt;

  mc_control #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .alu_op(alu_op), .pc_source(pc_source),
    .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one cycle and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if ({pc_en, mem_read, mem_write, ir_write, reg_write, illegal} !== 6'b0) begin errors++; $display("FAIL reset_strobes got %b exp 000000", {pc_en, mem_read, mem_write, ir_write, reg_write, illegal}); end
    checks++; if (instr_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", instr_cnt); end
    checks++; if ({alu_op, alu_src_b} !== 5'b001_01) begin errors++; $display("FAIL reset_selects got %b exp 00101", {alu_op, alu_src_b}); end
    rst_n = 1'b1;
    #1;
    exp_cnt = 4'd0;
    checks++; if ({pc_en, ir_write, mem_read} !== 3'b111) begin errors++; $display("FAIL fetch_strobes got %b exp 111", {pc_en, ir_write, mem_read}); end
    checks++; if (alu_op !== 3'd1) begin errors++; $display("FAIL fetch_alu_op got %0d exp 1", alu_op); end
  endtask

  task automatic test_rtype();
    logic [5:0] fns[2];
    logic [2:0] ops[2];
    fns = '{6'h22, 6'h27};
    ops = '{3'd2, 3'd6};
    for (int i = 0; i < 2; i++) begin
      opcode = 6'h00; funct = fns[i];
      tick();
      checks++; if (state !== 4'd1 || alu_src_b !== 2'b11) begin errors++; $display("FAIL r_decode got st=%0d srcb=%b exp st=1 srcb=11", state, alu_src_b); end
      tick();
      opcode = 6'h3F; funct = 6'h00;  // IR fields must already be latched
      #1;
      checks++; if (state !== 4'd6 || alu_op !== ops[i] || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin errors++; $display("FAIL r_exec got st=%0d op=%0d a=%b b=%b exp st=6 op=%0d a=1 b=00", state, alu_op, alu_src_a, alu_src_b, ops[i]); end
      tick();
      checks++; if (state !== 4'd7 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin errors++; $display("FAIL r_wb got st=%0d rw=%b rd=%b m2r=%b exp st=7 rw=1 rd=1 m2r=0", state, reg_write, reg_dst, mem_to_reg); end
      tick();
      exp_cnt++;
      checks++; if (state !== 4'd0 || instr_cnt !== exp_cnt) begin errors++; $display("FAIL r_retire got st=%0d cnt=%0d exp st=0 cnt=%0d", state, instr_cnt, exp_cnt); end
    end
  endtask

  task automatic test_lw_sw();
    opcode = 6'h23;
    tick();
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL lw_decode got %0d exp 1", state); end
    tick();
    checks++; if (state !== 4'd2 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || ext_zero !== 1'b0 || alu_op !== 3'd1) begin errors++; $display("FAIL lw_addr got st=%0d a=%b b=%b ez=%b op=%0d exp st=2 a=1 b=10 ez=0 op=1", state, alu_src_a, alu_src_b, ext_zero, alu_op); end
    tick();
    checks++; if (state !== 4'd3 || mem_read !== 1'b1 || i_or_d !== 1'b1) begin errors++; $display("FAIL lw_rd got st=%0d mr=%b iod=%b exp st=3 mr=1 iod=1", state, mem_read, i_or_d); end
    tick();
    checks++; if (state !== 4'd4 || reg_write !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin errors++; $display("FAIL lw_wb got st=%0d rw=%b m2r=%b rd=%b exp st=4 rw=1 m2r=1 rd=0", state, reg_write, mem_to_reg, reg_dst); end
    tick();
    exp_cnt++;
    checks++; if (state !== 4'd0 || instr_cnt !== exp_cnt) begin errors++; $display("FAIL lw_retire got st=%0d cnt=%0d exp st=0 cnt=%0d", state, instr_cnt, exp_cnt); end
    opcode = 6'h2B;
    tick();
    tick();
    checks++; if (state !== 4'd2) begin errors++; $display("FAIL sw_addr got %0d exp 2", state); end
    tick();
    checks++; if (state !== 4'd5 || mem_write !== 1'b1 || i_or_d !== 1'b1 || reg_write !== 1'b0) begin errors++; $display("FAIL sw_wr got st=%0d mw=%b iod=%b rw=%b exp st=5 mw=1 iod=1 rw=0", state, mem_write, i_or_d, reg_write); end
    tick();
    exp_cnt++;
    checks++; if (state !== 4'd0 || instr_cnt !== exp_cnt) begin errors++; $display("FAIL sw_retire got st=%0d cnt=%0d exp st=0 cnt=%0d", state, instr_cnt, exp_cnt); end
  endtask

  task automatic test_itype();
    logic [5:0] opc[3];
    logic [2:0] ops[3];
    logic       ezs[3];
    opc = '{6'h08, 6'h0D, 6'h0E};
    ops = '{3'd1, 3'd4, 3'd5};
    ezs = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      opcode = opc[i];
      tick();
      tick();
      opcode = 6'h00;
      #1;
      checks++; if (state !== 4'd10 || alu_op !== ops[i] || ext_zero !== ezs[i] || alu_src_b !== 2'b10 || alu_src_a !== 1'b1) begin errors++; $display("FAIL i_exec got st=%0d op=%0d ez=%b b=%b a=%b exp st=10 op=%0d ez=%b b=10 a=1", state, alu_op, ext_zero, alu_src_b, alu_src_a, ops[i], ezs[i]); end
      tick();
      checks++; if (state !== 4'd11 || alu_op !== ops[i] || ext_zero !== ezs[i] || alu_src_b !== 2'b10 || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0) begin errors++; $display("FAIL i_wb got st=%0d op=%0d ez=%b b=%b rw=%b rd=%b m2r=%b exp st=11 op=%0d ez=%b b=10 rw=1 rd=0 m2r=0", state, alu_op, ext_zero, alu_src_b, reg_write, reg_dst, mem_to_reg, ops[i], ezs[i]); end
      tick();
      exp_cnt++;
      checks++; if (state !== 4'd0 || instr_cnt !== exp_cnt) begin errors++; $display("FAIL i_retire got st=%0d cnt=%0d exp st=0 cnt=%0d", state, instr_cnt, exp_cnt); end
    end
  endtask

  task automatic test_branch();
    logic [5:0] opc[2];
    logic       bne[2];
    opc = '{6'h04, 6'h05};
    bne = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      opcode = opc[i]; zero = 1'b0;
      tick();
      tick();
      checks++; if (state !== 4'd8 || pc_source !== 2'b01 || alu_op !== 3'd2) begin errors++; $display("FAIL br_state got st=%0d ps=%b op=%0d exp st=8 ps=01 op=2", state, pc_source, alu_op); end
      zero = 1'b1;
      #1;
      checks++; if (pc_en !== ~bne[i]) begin errors++; $display("FAIL br_zero1 got %b exp %b", pc_en, ~bne[i]); end
      zero = 1'b0;
      #1;
      checks++; if (pc_en !== bne[i]) begin errors++; $display("FAIL br_zero0 got %b exp %b", pc_en, bne[i]); end
      tick();
      exp_cnt++;
      checks++; if (state !== 4'd0 || instr_cnt !== exp_cnt) begin errors++; $display("FAIL br_retire got st=%0d cnt=%0d exp st=0 cnt=%0d", state, instr_cnt, exp_cnt); end
    end
    opcode = 6'h02;
    tick();
    tick();
    checks++; if (state !== 4'd9 || pc_source !== 2'b10 || pc_en !== 1'b1) begin errors++; $display("FAIL jump got st=%0d ps=%b pe=%b exp st=9 ps=10 pe=1", state, pc_source, pc_en); end
    tick();
    exp_cnt++;
    checks++; if (state !== 4'd0 || instr_cnt !== exp_cnt) begin errors++; $display("FAIL j_retire got st=%0d cnt=%0d exp st=0 cnt=%0d", state, instr_cnt, exp_cnt); end
  endtask

  task automatic test_illegal();
    logic [5:0] opc[2];
    opc = '{6'h3F, 6'h00};
    for (int i = 0; i < 2; i++) begin
      opcode = opc[i]; funct = 6'h00;
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_fetch got %b exp 0", illegal); end
      tick();
      checks++; if (state !== 4'd1 || illegal !== 1'b1) begin errors++; $display("FAIL ill_decode got st=%0d ill=%b exp st=1 ill=1", state, illegal); end
      tick();
      checks++; if (state !== 4'd0 || illegal !== 1'b0 || instr_cnt !== exp_cnt) begin errors++; $display("FAIL ill_after got st=%0d ill=%b cnt=%0d exp st=0 ill=0 cnt=%0d", state, illegal, instr_cnt, exp_cnt); end
    end
  endtask

  task automatic test_midop_reset();
    opcode = 6'h23;
    tick();
    tick();
    tick();
    checks++; if (state !== 4'd3) begin errors++; $display("FAIL mid_pre got %0d exp 3", state); end
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 4'd0 || reg_write !== 1'b0 || mem_read !== 1'b0 || instr_cnt !== 4'd0) begin errors++; $display("FAIL mid_async got st=%0d rw=%b mr=%b cnt=%0d exp st=0 rw=0 mr=0 cnt=0", state, reg_write, mem_read, instr_cnt); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (state !== 4'd0 || reg_write !== 1'b0) begin errors++; $display("FAIL mid_hold got st=%0d rw=%b exp st=0 rw=0", state, reg_write); end
    end
    rst_n = 1'b1;
    exp_cnt = 4'd0;
    opcode = 6'h02;
    tick();
    checks++; if (state !== 4'd1 || reg_write !== 1'b0) begin errors++; $display("FAIL mid_restart got st=%0d rw=%b exp st=1 rw=0", state, reg_write); end
    tick();
    tick();
    exp_cnt++;
    checks++; if (instr_cnt !== exp_cnt) begin errors++; $display("FAIL mid_cnt got %0d exp %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_wrap();
    opcode = 6'h02;
    while (exp_cnt != 4'd15) begin
      repeat (3) tick();
      exp_cnt++;
    end
    checks++; if (instr_cnt !== 4'd15) begin errors++; $display("FAIL wrap_max got %0d exp 15", instr_cnt); end
    repeat (3) tick();
    exp_cnt++;
    checks++; if (instr_cnt !== 4'd0 || state !== 4'd0) begin errors++; $display("FAIL wrap_zero got cnt=%0d st=%0d exp cnt=0 st=0", instr_cnt, state); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_sw();
    test_itype();
    test_branch();
    test_illegal();
    test_midop_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the lab05 MIPS-subset CPU. It sits directly upstream of the ALU. It decodes the instruction register fields, steps a Moore FSM through fetch, decode, execute, memory and writeback, and drives the datapath strobes plus the 3-bit `alu_op`, encoded exactly as the ALU consumes it. It also keeps a retired-instruction counter for the bench and debug.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `opcode`  in  6: IR[31:26], valid from the cycle after FETCH.
- `funct`  in  6: IR[5:0].
- `zero`  in  1: asserted when the current ALU result equals 0.
- `pc_en`  out  1: PC load enable; branch condition already folded in.
- `i_or_d`  out  1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write`, `reg_write`  out  1 each: strobes.
- `reg_dst`  out  1: write-register select; 0 = rt, 1 = rd.
- `mem_to_reg`  out  1: writeback data select; 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1: ALU A select; 0 = PC, 1 = register A.
- `alu_src_b`  out  2: ALU B select; 00 = B, 01 = 4, 10 = ext(imm), 11 = sext(imm)<<2.
- `ext_zero`  out  1: immediate extension; 1 = zero-extend, 0 = sign-extend.
- `alu_op`  out  3: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOR.
- `pc_source`  out  2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal`  out  1: one-cycle pulse on an unsupported opcode or funct.
- `state`  out  4: current state code.
- `instr_cnt`  out  CNT_W: count of retired instructions.

## Operation
- Supported instructions:
  - R-type (opcode 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27.
  - addi 0x08, andi 0x0C, ori 0x0D, xori 0x0E.
  - lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
- `opcode` and `funct` are latched internally on the DECODE cycle. All later states use the latched copies.
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEM_ADDR (lw/sw), R_EXEC (R-type with a legal funct), I_EXEC (addi/andi/ori/xori), BRANCH (beq/bne), JUMP (j), else FETCH with `illegal`=1.
  - MEM_ADDR→MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD→MEM_WB.
  - R_EXEC→R_WB.
  - I_EXEC→I_WB.
  - MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP→FETCH.
  - Codes 12–15 → FETCH.
- Outputs per state. Any strobe not listed is 0; `alu_op` defaults to NOP.
  - FETCH: mem_read, ir_write, pc_en; i_or_d=0, src_a=0, src_b=01, ADD, pc_source=00.
  - DECODE: src_a=0, src_b=11, ADD (branch target into ALUOut).
  - MEM_ADDR: src_a=1, src_b=10, ext_zero=0, ADD.
  - MEM_RD: mem_read, i_or_d=1.
  - MEM_WB: reg_write, reg_dst=0, mem_to_reg=1.
  - MEM_WR: mem_write, i_or_d=1.
  - R_EXEC: src_a=1, src_b=00, alu_op from latched funct.
  - R_WB: reg_write, reg_dst=1, mem_to_reg=0.
  - I_EXEC: src_a=1, src_b=10; ext_zero=1 for andi/ori/xori, 0 for addi; alu_op ADD/AND/OR/XOR respectively.
  - I_WB: reg_write, reg_dst=0, mem_to_reg=0. Hold I_EXEC's alu_op, src_a, src_b and ext_zero so ALUOut stays stable.
  - BRANCH: src_a=1, src_b=00, SUB, pc_source=01; pc_en = zero XOR is_bne.
  - JUMP: pc_source=10, pc_en=1.
- Outputs are decoded combinationally from `state`, the latched fields and `zero`.
- `instr_cnt` increments by 1 on every cycle whose next state is FETCH, except the illegal DECODE cycle. It wraps from 2^CNT_W−1 to 0.

## Timing
- Reset: while `rst_n`=0, `state`=FETCH, `instr_cnt`=0 and the latched fields are 0.
  - All strobes (pc_en, mem_read, mem_write, ir_write, reg_write) and `illegal` are forced 0.
  - Select outputs and `alu_op` show FETCH values.
- The first FETCH strobes assert in the first cycle after `rst_n` rises.
- Cycles per instruction: lw 5, sw/R/I 4, beq/bne/j 3, illegal 2.
- If reset asserts mid-instruction, state returns to FETCH immediately with no partial writeback.
- `zero` is sampled only in BRANCH, in the same cycle. `pc_en` can toggle within that cycle.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → `state`=0, all strobes 0, `instr_cnt`=0. After release, FETCH asserts `pc_en`, `ir_write` and `mem_read`; `alu_op`=1.
- R-type: opcode 0x00 with funct 0x22, then 0x27 → states 0,1,6,7. `alu_op`=2, then 6. `reg_write`/`reg_dst`=1 in state 7. `instr_cnt` +1 per instruction.
- lw then sw: lw passes states 0,1,2,3,4 with `mem_to_reg`=1 in 4. sw passes 0,1,2,5 with `mem_write`=1 and `i_or_d`=1 in 5.
- Branches:
  - beq with zero=1 → `pc_en`=1 and `pc_source`=01 in state 8.
  - beq with zero=0 → `pc_en`=0.
  - bne inverts both cases.
  - j → `pc_source`=10 and `pc_en`=1 in state 9.
- Illegal: opcode 0x3F or R-type funct 0x00 → `illegal`=1 for exactly the DECODE cycle, next state 0, `instr_cnt` unchanged.
- Mid-op reset and wrap: assert `rst_n`=0 in MEM_RD → `state`=0 and `reg_write` never asserts. With `CNT_W`=4, 16 retired instructions → `instr_cnt` wraps to 0.
